// File: rtl/reservoir_input_sequencer_if.sv
// Signal bundle between an upstream sample source, the input sequencer and the reservoir.
// The master modport is the sample/mask/reservoir-handshake side; the slave modport is the sequencer.
`timescale 1ns/1ps
interface reservoir_input_sequencer_if #(
  parameter int NUM_VIRTUAL_NODES = 10,
  parameter int DATA_WIDTH        = 32,
  parameter int SAMPLE_WIDTH      = 16,
  parameter int MASK_WIDTH        = 10
);
  localparam int AW = (NUM_VIRTUAL_NODES > 1) ? $clog2(NUM_VIRTUAL_NODES) : 1;

  logic                    sample_valid;
  logic                    sample_ready;
  logic [SAMPLE_WIDTH-1:0] sample_data;
  logic                    mask_wr_en;
  logic [AW-1:0]           mask_wr_addr;
  logic [MASK_WIDTH-1:0]   mask_wr_data;
  logic                    mask_wr_dropped;
  logic                    res_en;
  logic [DATA_WIDTH-1:0]   res_din;
  logic                    res_valid;
  logic [AW-1:0]           node_idx;
  logic                    busy;
  logic                    sat;
  logic                    sample_done;

  modport master (
    output sample_valid, sample_data, mask_wr_en, mask_wr_addr, mask_wr_data, res_valid,
    input  sample_ready, mask_wr_dropped, res_en, res_din, node_idx, busy, sat, sample_done
  );

  modport slave (
    input  sample_valid, sample_data, mask_wr_en, mask_wr_addr, mask_wr_data, res_valid,
    output sample_ready, mask_wr_dropped, res_en, res_din, node_idx, busy, sat, sample_done
  );
endinterface

// File: rtl/reservoir_input_sequencer.sv
// Feeds one sample into the reservoir as NUM_VIRTUAL_NODES masked updates, one en pulse per
// node, waiting for the reservoir to drop and re-raise res_valid before moving on.
`timescale 1ns/1ps
module reservoir_input_sequencer #(
  parameter int NUM_VIRTUAL_NODES = 10,
  parameter int DATA_WIDTH        = 32,
  parameter int SAMPLE_WIDTH      = 16,
  parameter int MASK_WIDTH        = 10,
  parameter int MASK_FRAC_BITS    = 8
) (
  input logic                        clk,
  input logic                        rst,
  reservoir_input_sequencer_if.slave bus
);
  localparam int              AW         = (NUM_VIRTUAL_NODES > 1) ? $clog2(NUM_VIRTUAL_NODES) : 1;
  localparam int              PW         = SAMPLE_WIDTH + MASK_WIDTH;
  localparam logic [AW:0]     NODE_LIMIT = (AW+1)'(NUM_VIRTUAL_NODES);
  localparam logic [AW-1:0]   LAST_NODE  = AW'(NUM_VIRTUAL_NODES - 1);

  typedef enum logic [2:0] {IDLE, READ, MULT, ISSUE, ACK} state_t;

  state_t                  state_reg, state_next;
  logic [SAMPLE_WIDTH-1:0] sample_reg, sample_next;
  logic [AW-1:0]           node_idx_reg, node_idx_next;
  logic [DATA_WIDTH-1:0]   res_din_reg, res_din_next;
  logic                    res_en_reg, res_en_next;
  logic                    sat_reg, sat_next;
  logic                    done_reg, done_next;
  logic                    seen_low_reg, seen_low_next;
  logic                    drop_reg, drop_next;
  logic                    ready_reg, ready_next;
  logic                    busy_reg, busy_next;

  logic [MASK_WIDTH-1:0]   mask_mem [NUM_VIRTUAL_NODES];
  logic [MASK_WIDTH-1:0]   mask_rd_reg;

  logic [PW-1:0]           product;
  logic [PW-1:0]           scaled;
  logic                    overflow;
  logic                    wr_ok;

  assign product  = PW'(sample_reg) * PW'(mask_rd_reg);
  assign scaled   = product >> MASK_FRAC_BITS;
  assign overflow = |scaled[PW-1:SAMPLE_WIDTH];
  assign wr_ok    = (state_reg == IDLE) && ({1'b0, bus.mask_wr_addr} < NODE_LIMIT);

  // Mask RAM: no reset, registered read always follows node_idx so READ needs no extra enable.
  always_ff @(posedge clk) begin
    if (bus.mask_wr_en && wr_ok) begin
      mask_mem[bus.mask_wr_addr] <= bus.mask_wr_data;
    end
    mask_rd_reg <= mask_mem[node_idx_reg];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      sample_reg   <= '0;
      node_idx_reg <= '0;
      res_din_reg  <= '0;
      res_en_reg   <= 1'b0;
      sat_reg      <= 1'b0;
      done_reg     <= 1'b0;
      seen_low_reg <= 1'b0;
      drop_reg     <= 1'b0;
      ready_reg    <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sample_reg   <= sample_next;
      node_idx_reg <= node_idx_next;
      res_din_reg  <= res_din_next;
      res_en_reg   <= res_en_next;
      sat_reg      <= sat_next;
      done_reg     <= done_next;
      seen_low_reg <= seen_low_next;
      drop_reg     <= drop_next;
      ready_reg    <= ready_next;
      busy_reg     <= busy_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    sample_next   = sample_reg;
    node_idx_next = node_idx_reg;
    res_din_next  = res_din_reg;
    res_en_next   = 1'b0;
    sat_next      = 1'b0;
    done_next     = 1'b0;
    seen_low_next = seen_low_reg;
    drop_next     = bus.mask_wr_en && !wr_ok;

    case (state_reg)
      IDLE: begin
        if (bus.sample_valid) begin
          sample_next   = bus.sample_data;
          node_idx_next = '0;
          state_next    = READ;
        end
      end
      READ: begin
        state_next = MULT;
      end
      MULT: begin
        // res_din is only loaded here, so it stays put while the reservoir consumes it.
        res_din_next                   = '0;
        res_din_next[SAMPLE_WIDTH-1:0] = overflow ? {SAMPLE_WIDTH{1'b1}} : scaled[SAMPLE_WIDTH-1:0];
        sat_next                       = overflow;
        state_next                     = ISSUE;
      end
      ISSUE: begin
        if (bus.res_valid) begin
          res_en_next   = 1'b1;
          seen_low_next = 1'b0;
          state_next    = ACK;
        end
      end
      ACK: begin
        // Require a low phase first: res_valid is still high in the cycle en is presented.
        if (!bus.res_valid) begin
          seen_low_next = 1'b1;
        end else if (seen_low_reg) begin
          if (node_idx_reg == LAST_NODE) begin
            done_next     = 1'b1;
            node_idx_next = '0;
            state_next    = IDLE;
          end else begin
            node_idx_next = node_idx_reg + 1'b1;
            state_next    = READ;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    ready_next = (state_next == IDLE);
    busy_next  = (state_next != IDLE);
  end

  assign bus.sample_ready    = ready_reg;
  assign bus.busy            = busy_reg;
  assign bus.node_idx        = node_idx_reg;
  assign bus.res_din         = res_din_reg;
  assign bus.res_en          = res_en_reg;
  assign bus.sat             = sat_reg;
  assign bus.sample_done     = done_reg;
  assign bus.mask_wr_dropped = drop_reg;
endmodule

// File: tb/tb_reservoir_input_sequencer.sv
// Directed bench for reservoir_input_sequencer with a small reservoir handshake model.
`timescale 1ns/1ps
module tb_reservoir_input_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reservoir_input_sequencer_if #(.NUM_VIRTUAL_NODES(10), .DATA_WIDTH(32),
                                 .SAMPLE_WIDTH(16), .MASK_WIDTH(10)) bus ();

  reservoir_input_sequencer #(.NUM_VIRTUAL_NODES(10), .DATA_WIDTH(32), .SAMPLE_WIDTH(16),
                              .MASK_WIDTH(10), .MASK_FRAC_BITS(8))
    dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks   = 0;
  int failures = 0;

  // Reservoir model: on en, res_valid low for ack_delay cycles, then high again.
  int ack_delay   = 6;
  int model_cnt   = 0;
  bit model_clear = 1'b1;
  always @(posedge clk) begin
    if (model_clear) begin
      bus.res_valid <= 1'b1;
      model_cnt     <= 0;
    end else if (model_cnt > 0) begin
      model_cnt <= model_cnt - 1;
      if (model_cnt == 1) bus.res_valid <= 1'b1;
    end else if (bus.res_en && bus.res_valid) begin
      bus.res_valid <= 1'b0;
      model_cnt     <= ack_delay;
    end
  end

  logic [31:0] en_din[$];
  int          en_node[$];
  int          done_count, accept_count, sat_count, sat_node;
  always @(posedge clk) begin
    if (bus.res_en) begin
      en_din.push_back(bus.res_din);
      en_node.push_back(int'(bus.node_idx));
    end
    if (bus.sample_done) done_count++;
    if (bus.sample_valid && bus.sample_ready && !rst) accept_count++;
    if (bus.sat) begin
      sat_count++;
      sat_node = int'(bus.node_idx);
    end
  end

  function automatic logic [31:0] din_at(input int i);
    return (i < en_din.size()) ? en_din[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic clear_mon();
    en_din.delete();
    en_node.delete();
    done_count = 0; accept_count = 0; sat_count = 0; sat_node = -1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_mask(input int addr, input logic [9:0] data);
    bus.mask_wr_en = 1'b1; bus.mask_wr_addr = 4'(addr); bus.mask_wr_data = data;
    @(negedge clk);
    bus.mask_wr_en = 1'b0;
  endtask

  // Returns at the negedge right after the accepting clock edge.
  task automatic offer_sample(input logic [15:0] data, output bit ok);
    ok = 1'b0;
    bus.sample_valid = 1'b1; bus.sample_data = data;
    for (int i = 0; i < 200; i++) begin
      if (bus.sample_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    bus.sample_valid = 1'b0;
  endtask

  // Returns at the negedge where sample_done is high.
  task automatic wait_done(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (bus.sample_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; model_clear = 1'b1;
    tick(3);
    checks++; if (bus.sample_ready !== 1'b1) begin failures++; $display("FAIL reset_sample_ready: got %0b want 1", bus.sample_ready); end
    checks++; if (bus.res_en !== 1'b0) begin failures++; $display("FAIL reset_res_en: got %0b want 0", bus.res_en); end
    checks++; if (bus.res_din !== 32'h0) begin failures++; $display("FAIL reset_res_din: got %h want 0", bus.res_din); end
    checks++; if (bus.node_idx !== 4'd0) begin failures++; $display("FAIL reset_node_idx: got %0d want 0", bus.node_idx); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
    checks++; if (bus.sat !== 1'b0) begin failures++; $display("FAIL reset_sat: got %0b want 0", bus.sat); end
    checks++; if (bus.sample_done !== 1'b0) begin failures++; $display("FAIL reset_sample_done: got %0b want 0", bus.sample_done); end
    checks++; if (bus.mask_wr_dropped !== 1'b0) begin failures++; $display("FAIL reset_dropped: got %0b want 0", bus.mask_wr_dropped); end
    rst = 1'b0; model_clear = 1'b0;
    tick(1);
  endtask

  task automatic test_unity_gain();
    bit ok;
    int bad;
    for (int i = 0; i < 10; i++) write_mask(i, 10'h100);
    ack_delay = 6;
    clear_mon();
    offer_sample(16'h1234, ok);
    checks++; if (!ok) begin failures++; $display("FAIL unity_accept: got timeout want accept"); end
    tick(2);
    checks++; if (bus.res_en !== 1'b0) begin failures++; $display("FAIL unity_early_en: got %0b want 0", bus.res_en); end
    tick(1);
    checks++; if (bus.res_en !== 1'b1) begin failures++; $display("FAIL unity_latency_en: got %0b want 1", bus.res_en); end
    wait_done(400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL unity_done: got timeout want sample_done"); end
    checks++; if (bus.sample_ready !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL unity_idle: got ready=%0b busy=%0b want ready=1 busy=0", bus.sample_ready, bus.busy); end
    tick(1);
    checks++; if (en_din.size() != 10) begin failures++; $display("FAIL unity_en_count: got %0d want 10", en_din.size()); end
    checks++; if (done_count != 1) begin failures++; $display("FAIL unity_done_count: got %0d want 1", done_count); end
    bad = 0;
    for (int i = 0; i < en_din.size(); i++) if (en_din[i] !== 32'h0000_1234 || en_node[i] != i) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL unity_din_node: got %0d bad pulses want 0", bad); end
  endtask

  task automatic test_saturation();
    bit ok;
    write_mask(0, 10'h3FF);
    write_mask(1, 10'h080);
    ack_delay = 3;
    clear_mon();
    offer_sample(16'hFFFF, ok);
    wait_done(400, ok);
    tick(1);
    checks++; if (en_din.size() != 10) begin failures++; $display("FAIL sat_en_count: got %0d want 10", en_din.size()); end
    checks++; if (din_at(0) !== 32'h0000_FFFF) begin failures++; $display("FAIL sat_node0_din: got %h want 0000ffff", din_at(0)); end
    checks++; if (din_at(1) !== 32'h0000_7FFF) begin failures++; $display("FAIL sat_node1_din: got %h want 00007fff", din_at(1)); end
    checks++; if (din_at(2) !== 32'h0000_FFFF) begin failures++; $display("FAIL sat_node2_din: got %h want 0000ffff", din_at(2)); end
    checks++; if (sat_count != 1 || sat_node != 0) begin failures++; $display("FAIL sat_pulse: got count=%0d node=%0d want count=1 node=0", sat_count, sat_node); end
  endtask

  task automatic test_stall();
    bit ok;
    bit seen;
    logic [31:0] held;
    int extra_en, din_moved, not_busy, ready_hi;
    clear_mon();
    ack_delay = 50;
    bus.sample_valid = 1'b1; bus.sample_data = 16'h0001;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.res_en) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin failures++; $display("FAIL stall_first_en: got timeout want res_en"); end
    held = bus.res_din;
    checks++; if (held !== 32'h0000_0003) begin failures++; $display("FAIL stall_din: got %h want 00000003", held); end
    extra_en = 0; din_moved = 0; not_busy = 0; ready_hi = 0;
    repeat (45) begin
      @(negedge clk);
      if (bus.res_en) extra_en++;
      if (bus.res_din !== held) din_moved++;
      if (bus.busy !== 1'b1) not_busy++;
      if (bus.sample_ready !== 1'b0) ready_hi++;
    end
    checks++; if (extra_en != 0) begin failures++; $display("FAIL stall_no_en: got %0d pulses want 0", extra_en); end
    checks++; if (din_moved != 0) begin failures++; $display("FAIL stall_din_stable: got %0d changes want 0", din_moved); end
    checks++; if (not_busy != 0) begin failures++; $display("FAIL stall_busy: got %0d idle cycles want 0", not_busy); end
    checks++; if (ready_hi != 0) begin failures++; $display("FAIL stall_ready: got %0d ready cycles want 0", ready_hi); end
    bus.sample_valid = 1'b0;
    ack_delay = 2;
    wait_done(1000, ok);
    tick(1);
    checks++; if (!ok || en_din.size() != 10 || accept_count != 1 || done_count != 1) begin failures++; $display("FAIL stall_finish: got done=%0b en=%0d acc=%0d dn=%0d want 1/10/1/1", ok, en_din.size(), accept_count, done_count); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit found;
    int stray;
    clear_mon();
    ack_delay = 6;
    offer_sample(16'h0200, ok);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.res_en && bus.node_idx == 4'd4) begin found = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!found) begin failures++; $display("FAIL rstmid_reach_node4: got timeout want node4 ack"); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.sample_ready !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_state: got ready=%0b busy=%0b want 1/0", bus.sample_ready, bus.busy); end
    checks++; if (bus.res_en !== 1'b0 || bus.res_din !== 32'h0 || bus.node_idx !== 4'd0) begin failures++; $display("FAIL rstmid_outputs: got en=%0b din=%h idx=%0d want 0/0/0", bus.res_en, bus.res_din, bus.node_idx); end
    checks++; if (bus.sat !== 1'b0 || bus.sample_done !== 1'b0) begin failures++; $display("FAIL rstmid_pulses: got sat=%0b done=%0b want 0/0", bus.sat, bus.sample_done); end
    rst = 1'b0;
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.res_en) stray++;
    end
    checks++; if (stray != 0) begin failures++; $display("FAIL rstmid_no_en: got %0d pulses want 0", stray); end
    clear_mon();
    offer_sample(16'h0100, ok);
    wait_done(400, ok);
    tick(1);
    checks++; if (en_din.size() != 10 || en_node[0] != 0) begin failures++; $display("FAIL rstmid_restart: got en=%0d first_node=%0d want 10/0", en_din.size(), (en_node.size() > 0) ? en_node[0] : -1); end
    checks++; if (din_at(0) !== 32'h0000_03FF) begin failures++; $display("FAIL rstmid_mask0: got %h want 000003ff", din_at(0)); end
    checks++; if (din_at(1) !== 32'h0000_0080) begin failures++; $display("FAIL rstmid_mask1: got %h want 00000080", din_at(1)); end
  endtask

  task automatic test_mask_drop();
    bit ok;
    clear_mon();
    ack_delay = 3;
    offer_sample(16'h0100, ok);
    tick(2);
    write_mask(2, 10'h000);
    checks++; if (bus.mask_wr_dropped !== 1'b1) begin failures++; $display("FAIL drop_busy: got %0b want 1", bus.mask_wr_dropped); end
    tick(1);
    checks++; if (bus.mask_wr_dropped !== 1'b0) begin failures++; $display("FAIL drop_pulse_width: got %0b want 0", bus.mask_wr_dropped); end
    wait_done(400, ok);
    tick(1);
    write_mask(10, 10'h000);
    checks++; if (bus.mask_wr_dropped !== 1'b1) begin failures++; $display("FAIL drop_range: got %0b want 1", bus.mask_wr_dropped); end
    write_mask(3, 10'h200);
    checks++; if (bus.mask_wr_dropped !== 1'b0) begin failures++; $display("FAIL drop_valid_write: got %0b want 0", bus.mask_wr_dropped); end
    clear_mon();
    offer_sample(16'h0100, ok);
    wait_done(400, ok);
    tick(1);
    checks++; if (din_at(2) !== 32'h0000_0100) begin failures++; $display("FAIL drop_mask2_kept: got %h want 00000100", din_at(2)); end
    checks++; if (din_at(3) !== 32'h0000_0200) begin failures++; $display("FAIL drop_mask3_written: got %h want 00000200", din_at(3)); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_mon();
    ack_delay = 3;
    bus.sample_valid = 1'b1; bus.sample_data = 16'h1234;
    wait_done(600, ok);
    checks++; if (!ok || bus.sample_ready !== 1'b1) begin failures++; $display("FAIL b2b_first_done: got done=%0b ready=%0b want 1/1", ok, bus.sample_ready); end
    bus.sample_data = 16'h0100;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1 || bus.sample_ready !== 1'b0) begin failures++; $display("FAIL b2b_second_accept: got busy=%0b ready=%0b want 1/0", bus.busy, bus.sample_ready); end
    bus.sample_valid = 1'b0;
    wait_done(600, ok);
    tick(1);
    checks++; if (!ok || en_din.size() != 20) begin failures++; $display("FAIL b2b_en_count: got done=%0b en=%0d want 1/20", ok, en_din.size()); end
    checks++; if (done_count != 2 || accept_count != 2) begin failures++; $display("FAIL b2b_counts: got done=%0d acc=%0d want 2/2", done_count, accept_count); end
    checks++; if (din_at(10) !== 32'h0000_03FF) begin failures++; $display("FAIL b2b_second_din: got %h want 000003ff", din_at(10)); end
  endtask

  initial begin
    rst = 1'b1;
    bus.sample_valid = 1'b0; bus.sample_data = '0;
    bus.mask_wr_en = 1'b0; bus.mask_wr_addr = '0; bus.mask_wr_data = '0;
    clear_mon();
    @(negedge clk);
    test_reset();
    test_unity_gain();
    test_saturation();
    test_stall();
    test_reset_mid();
    test_mask_drop();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
